// File: rtl/codec_map_dec_input_addr_gen_pkg.sv
// Shared types and elaboration checks for the MAP decoder input RAM read sequencer.
package codec_map_dec_input_addr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_e;

    // Read qualifiers travelling alongside the RAM read latency.
    typedef struct packed {
        logic val;
        logic sop;
        logic eop;
        logic mid;
    } qual_t;

    function automatic bit ram_lat_ok(int unsigned lat);
        return (lat >= 1) && (lat <= 3);
    endfunction

endpackage

// File: rtl/codec_map_dec_input_addr_gen_dly.sv
// Clock-enabled, synchronously clearable delay line for the read qualifiers.
module codec_map_dec_input_addr_gen_dly
    import codec_map_dec_input_addr_gen_pkg::*;
#(
    parameter int unsigned pDEPTH = 1
) (
    input  logic  iclk,
    input  logic  ireset,
    input  logic  iclkena,
    input  logic  iclear,
    input  qual_t idat,
    output qual_t odat
);

    qual_t pipe [pDEPTH];

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            for (int i = 0; i < int'(pDEPTH); i++) pipe[i] <= '0;
        end else if (iclkena) begin
            if (iclear) begin
                for (int i = 0; i < int'(pDEPTH); i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= idat;
                for (int i = 1; i < int'(pDEPTH); i++) pipe[i] <= pipe[i-1];
            end
        end
    end

    assign odat = pipe[pDEPTH-1];

endmodule

// File: rtl/codec_map_dec_input_addr_gen.sv
// Dual-direction read-address sweep for the MAP decoder input RAM, with the
// read qualifiers delayed to line up with the RAM output data.
module codec_map_dec_input_addr_gen
    import codec_map_dec_input_addr_gen_pkg::*;
#(
    parameter int unsigned pADDR_W  = 8,
    parameter int unsigned pRAM_LAT = 1
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               istart,
    input  logic [pADDR_W-2:0] ihlen_m1,
    input  logic               iabort,
    output logic               oread,
    output logic [pADDR_W-1:0] oraddr0,
    output logic [pADDR_W-1:0] oraddr1,
    output logic               oval,
    output logic               osop,
    output logic               oeop,
    output logic               omid,
    output logic               obusy,
    output logic               odone
);

    localparam logic [1:0] LAT_M1 = 2'(pRAM_LAT - 1);

    if (!ram_lat_ok(pRAM_LAT)) begin : g_bad_lat
        $error("pRAM_LAT must be in 1..3");
    end

    state_e             state;
    logic [pADDR_W-1:0] nm1;
    logic [pADDR_W-1:0] half;
    logic [1:0]         flush_cnt;
    qual_t              qual_in;
    qual_t              qual_out;

    // N/2 = ihlen_m1 + 1; fits in pADDR_W bits even when N = 2^pADDR_W.
    assign half = {1'b0, nm1[pADDR_W-1:1]} + pADDR_W'(1);

    // oraddr0 doubles as the pair counter k.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state     <= IDLE;
            nm1       <= '0;
            flush_cnt <= '0;
            oread     <= 1'b0;
            oraddr0   <= '0;
            oraddr1   <= '0;
            obusy     <= 1'b0;
        end else if (iclkena) begin
            if (iabort) begin
                state   <= IDLE;
                oread   <= 1'b0;
                oraddr0 <= '0;
                oraddr1 <= '0;
                obusy   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (istart) begin
                            state   <= RUN;
                            nm1     <= {ihlen_m1, 1'b1};
                            oread   <= 1'b1;
                            oraddr0 <= '0;
                            oraddr1 <= {ihlen_m1, 1'b1};
                            obusy   <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (oraddr0 == nm1) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                            oread     <= 1'b0;
                            oraddr0   <= '0;
                            oraddr1   <= '0;
                        end else begin
                            oraddr0 <= oraddr0 + pADDR_W'(1);
                            oraddr1 <= oraddr1 - pADDR_W'(1);
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == LAT_M1) begin
                            state <= IDLE;
                            obusy <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt + 2'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign qual_in = '{
        val: oread,
        sop: oread && (oraddr0 == '0),
        eop: oread && (oraddr0 == nm1),
        mid: oread && (oraddr0 == half)
    };

    codec_map_dec_input_addr_gen_dly #(
        .pDEPTH (pRAM_LAT)
    ) u_dly (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .iclear  (iabort),
        .idat    (qual_in),
        .odat    (qual_out)
    );

    assign oval  = qual_out.val;
    assign osop  = qual_out.sop;
    assign oeop  = qual_out.eop;
    assign omid  = qual_out.mid;
    // The last pair's eop emerging from the pipe marks completion; a flush kills both.
    assign odone = qual_out.eop;

endmodule

// File: tb/tb_codec_map_dec_input_addr_gen.sv
// Bench for codec_map_dec_input_addr_gen: three instances (L=1,2,3) share stimulus
// and are checked every cycle against a tick-count reference model.
module tb_codec_map_dec_input_addr_gen;

    localparam int W = 8;

    typedef struct packed {
        logic rd;
        logic val;
        logic sop;
        logic eop;
        logic mid;
        logic busy;
        logic done;
    } flags_t;

    typedef struct {
        logic       rd;
        logic [7:0] a0;
        logic [7:0] a1;
        flags_t     fl;
    } vec_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         ena   = 1'b1;
    logic         start = 1'b0;
    logic [W-2:0] hlen  = '0;
    logic         abort = 1'b0;

    logic         rd   [3];
    logic [W-1:0] a0   [3];
    logic [W-1:0] a1   [3];
    logic         val  [3];
    logic         sop  [3];
    logic         eop  [3];
    logic         mid  [3];
    logic         busy [3];
    logic         done [3];

    int checks   = 0;
    int failures = 0;
    int e    [3] = '{0, 0, 0};
    int nblk [3] = '{2, 2, 2};
    int done_cnt [3];
    int val_cnt  [3];

    always #5 clk = ~clk;

    codec_map_dec_input_addr_gen #(.pADDR_W(W), .pRAM_LAT(1)) u_l1 (
        .iclk(clk), .ireset(rst_n), .iclkena(ena), .istart(start), .ihlen_m1(hlen),
        .iabort(abort), .oread(rd[0]), .oraddr0(a0[0]), .oraddr1(a1[0]), .oval(val[0]),
        .osop(sop[0]), .oeop(eop[0]), .omid(mid[0]), .obusy(busy[0]), .odone(done[0])
    );
    codec_map_dec_input_addr_gen #(.pADDR_W(W), .pRAM_LAT(2)) u_l2 (
        .iclk(clk), .ireset(rst_n), .iclkena(ena), .istart(start), .ihlen_m1(hlen),
        .iabort(abort), .oread(rd[1]), .oraddr0(a0[1]), .oraddr1(a1[1]), .oval(val[1]),
        .osop(sop[1]), .oeop(eop[1]), .omid(mid[1]), .obusy(busy[1]), .odone(done[1])
    );
    codec_map_dec_input_addr_gen #(.pADDR_W(W), .pRAM_LAT(3)) u_l3 (
        .iclk(clk), .ireset(rst_n), .iclkena(ena), .istart(start), .ihlen_m1(hlen),
        .iabort(abort), .oread(rd[2]), .oraddr0(a0[2]), .oraddr1(a1[2]), .oval(val[2]),
        .osop(sop[2]), .oeop(eop[2]), .omid(mid[2]), .obusy(busy[2]), .odone(done[2])
    );

    function automatic flags_t act_flags(int j);
        return {rd[j], val[j], sop[j], eop[j], mid[j], busy[j], done[j]};
    endfunction

    // Outputs as a function of enabled ticks elapsed since the accepting edge.
    function automatic flags_t exp_flags(int j);
        flags_t f;
        int l  = j + 1;
        int n  = nblk[j];
        int ee = e[j];
        f.rd   = (ee >= 1) && (ee <= n);
        f.val  = (ee >= 1 + l) && (ee <= n + l);
        f.sop  = (ee == 1 + l);
        f.eop  = (ee == n + l);
        f.mid  = (ee == n / 2 + 1 + l);
        f.busy = (ee >= 1) && (ee <= n + l);
        f.done = (ee == n + l);
        return f;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        for (int j = 0; j < 3; j++) begin
            if (!rst_n) begin
                e[j] = 0;
            end else if (ena) begin
                if (abort) begin
                    e[j] = 0;
                end else if (e[j] != 0) begin
                    e[j]++;
                    if (e[j] > nblk[j] + j + 1) e[j] = 0;
                end else if (start) begin
                    e[j]    = 1;
                    nblk[j] = 2 * (int'(hlen) + 1);
                end
            end
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < 3; j++) begin
            flags_t x;
            logic [7:0] ea0;
            logic [7:0] ea1;
            x = exp_flags(j);
            checks++;
            if (act_flags(j) !== x) begin
                failures++;
                $display("FAIL model_flags L=%0d at %0t: got %b expected %b (rd val sop eop mid busy done)",
                         j + 1, $time, act_flags(j), x);
            end
            if (x.rd) begin
                ea0 = 8'(e[j] - 1);
                ea1 = 8'(nblk[j] - e[j]);
                checks++;
                if ({a0[j], a1[j]} !== {ea0, ea1}) begin
                    failures++;
                    $display("FAIL model_addr L=%0d at %0t: got (%0d,%0d) expected (%0d,%0d)",
                             j + 1, $time, a0[j], a1[j], ea0, ea1);
                end
                checks++;
                if (a0[j][0] === a1[j][0]) begin
                    failures++;
                    $display("FAIL bank_parity L=%0d at %0t: got (%0d,%0d) expected opposite LSBs",
                             j + 1, $time, a0[j], a1[j]);
                end
            end
            if (done[j] === 1'b1) done_cnt[j]++;
            if (val[j] === 1'b1) val_cnt[j]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_cnt();
        for (int j = 0; j < 3; j++) begin
            done_cnt[j] = 0;
            val_cnt[j]  = 0;
        end
    endtask

    task automatic run_block(input int h);
        start = 1'b1;
        hlen  = 7'(h);
        tick();
        start = 1'b0;
        idle(2 * (h + 1) + 5);
    endtask

    task automatic chk_all_zero(input string name);
        for (int j = 0; j < 3; j++)
            chk(name, int'({rd[j], a0[j], a1[j], val[j], sop[j], eop[j], mid[j], busy[j], done[j]}), 0);
    endtask

    vec_t tbl [10];

    initial begin
        // N=8, L=1 trace, ticks t+1..t+10: {rd, a0, a1, {rd val sop eop mid busy done}}
        tbl[0] = '{1'b1, 8'd0, 8'd7, 7'b1000010};
        tbl[1] = '{1'b1, 8'd1, 8'd6, 7'b1110010};
        tbl[2] = '{1'b1, 8'd2, 8'd5, 7'b1100010};
        tbl[3] = '{1'b1, 8'd3, 8'd4, 7'b1100010};
        tbl[4] = '{1'b1, 8'd4, 8'd3, 7'b1100010};
        tbl[5] = '{1'b1, 8'd5, 8'd2, 7'b1100110};
        tbl[6] = '{1'b1, 8'd6, 8'd1, 7'b1100010};
        tbl[7] = '{1'b1, 8'd7, 8'd0, 7'b1100010};
        tbl[8] = '{1'b0, 8'd0, 8'd0, 7'b0101011};
        tbl[9] = '{1'b0, 8'd0, 8'd0, 7'b0000000};

        clr_cnt();
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset_state");
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Directed N=8 block against the table on the L=1 instance
        start = 1'b1;
        hlen  = 7'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl_flags[%0d]", i), int'(act_flags(0)), int'(tbl[i].fl));
            if (tbl[i].rd)
                chk($sformatf("tbl_addr[%0d]", i), int'({a0[0], a1[0]}),
                    int'({tbl[i].a0, tbl[i].a1}));
            tick();
        end
        idle(4);

        // Size boundaries
        run_block(0);
        run_block(127);
        run_block(0);
        run_block(127);

        // Random clock enable, N=16
        for (int c = 0; c < 400; c++) begin
            ena   = ($urandom_range(0, 1) == 1);
            start = ($urandom_range(0, 9) < 3);
            hlen  = 7'd7;
            tick();
        end
        ena   = 1'b1;
        start = 1'b0;
        idle(24);

        // Start while busy is ignored; exactly one odone per instance
        clr_cnt();
        start = 1'b1;
        hlen  = 7'd3;
        tick();
        start = 1'b0;
        idle(2);
        start = 1'b1;
        hlen  = 7'd5;
        tick();
        start = 1'b0;
        idle(14);
        for (int j = 0; j < 3; j++) chk($sformatf("busy_start_done_cnt L=%0d", j + 1), done_cnt[j], 1);

        // Abort at t+4
        start = 1'b1;
        hlen  = 7'd3;
        tick();
        start = 1'b0;
        idle(3);
        abort = 1'b1;
        clr_cnt();
        tick();
        abort = 1'b0;
        chk("abort_oread_l2", int'(rd[1]), 0);
        idle(12);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("abort_no_val L=%0d", j + 1), val_cnt[j], 0);
            chk($sformatf("abort_no_done L=%0d", j + 1), done_cnt[j], 0);
        end
        clr_cnt();
        run_block(3);
        for (int j = 0; j < 3; j++) chk($sformatf("post_abort_done L=%0d", j + 1), done_cnt[j], 1);

        // Asynchronous reset mid-block at t+5
        start = 1'b1;
        hlen  = 7'd3;
        tick();
        start = 1'b0;
        idle(4);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset_mid");
        for (int j = 0; j < 3; j++) e[j] = 0;
        @(negedge clk);
        clr_cnt();
        idle(2);
        rst_n = 1'b1;
        idle(2);
        for (int j = 0; j < 3; j++) chk($sformatf("reset_no_done L=%0d", j + 1), done_cnt[j], 0);
        run_block(3);

        // Random lengths, enables and occasional aborts
        for (int c = 0; c < 600; c++) begin
            ena   = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 99) < 2);
            hlen  = 7'($urandom_range(0, 31));
            tick();
        end
        ena   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        idle(70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
